// File: rtl/rob_marker_pkg.sv
// Shared constants and types for the ROB marker capture stage: event codes,
// phase codes and the queued entry layout.
package rob_marker_pkg;

  localparam logic [3:0] VCTM_S  = 4'd0;
  localparam logic [3:0] VCTM_E  = 4'd1;
  localparam logic [3:0] DELAY_S = 4'd2;
  localparam logic [3:0] DELAY_E = 4'd3;
  localparam logic [3:0] TEXE_S  = 4'd4;
  localparam logic [3:0] TEXE_E  = 4'd5;
  localparam logic [3:0] LEAK_S  = 4'd6;
  localparam logic [3:0] LEAK_E  = 4'd7;
  localparam logic [3:0] INIT_S  = 4'd8;
  localparam logic [3:0] INIT_E  = 4'd9;
  localparam logic [3:0] BIM_S   = 4'd10;
  localparam logic [3:0] BIM_E   = 4'd11;
  localparam logic [3:0] TRAIN_S = 4'd12;
  localparam logic [3:0] TRAIN_E = 4'd13;
  localparam logic [3:0] EXIT    = 4'd14;

  localparam logic [3:0] PHASE_VCTM  = 4'd0;
  localparam logic [3:0] PHASE_DELAY = 4'd1;
  localparam logic [3:0] PHASE_TEXE  = 4'd2;
  localparam logic [3:0] PHASE_LEAK  = 4'd3;
  localparam logic [3:0] PHASE_INIT  = 4'd4;
  localparam logic [3:0] PHASE_BIM   = 4'd5;
  localparam logic [3:0] PHASE_TRAIN = 4'd6;
  localparam logic [3:0] PHASE_EXIT  = 4'd7;
  localparam logic [3:0] PHASE_IDLE  = 4'd15;

  typedef enum logic [3:0] {
    PH_VCTM  = PHASE_VCTM,
    PH_DELAY = PHASE_DELAY,
    PH_TEXE  = PHASE_TEXE,
    PH_LEAK  = PHASE_LEAK,
    PH_INIT  = PHASE_INIT,
    PH_BIM   = PHASE_BIM,
    PH_TRAIN = PHASE_TRAIN,
    PH_EXIT  = PHASE_EXIT,
    PH_IDLE  = PHASE_IDLE
  } phase_t;

  localparam logic [19:0] MARKER_LOW = 20'h02013;
  localparam logic [3:0]  MAX_CODE   = 4'd14;

  // Entry layout for the default 6-bit ROB index; wider cores pass their own type.
  localparam int ENTRY_IDW = 6;
  typedef struct packed {
    logic [3:0]           code;
    logic                 deq;
    logic [ENTRY_IDW-1:0] idx;
  } marker_entry_t;

  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[31:24] == 8'h00) && (inst[19:0] == MARKER_LOW) && (inst[23:20] <= MAX_CODE);
  endfunction

endpackage

// File: rtl/rob_marker_queue_fifo.sv
// Multi-push, single-pop FIFO. The caller never pushes more than 'free' entries,
// so the push path needs no full check of its own.
module marker_fifo
  import rob_marker_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter int  LANES   = 2,
  parameter type entry_t = marker_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1,
  localparam int CW      = $clog2(LANES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  entry_t [LANES-1:0]       push_data,
  input  logic   [CW-1:0]          push_num,
  input  logic                     pop,
  output logic                     head_valid,
  output entry_t                   head,
  output logic   [PW-1:0]          free
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          do_pop;
  logic [AW-1:0] waddr [LANES];

  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  assign free       = PW'(DEPTH) - count + PW'(do_pop);
  // Empty head reads as zero so the outputs have a defined reset value.
  assign head       = head_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      waddr[i] = wr_ptr[AW-1:0] + AW'(i);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < push_num) mem[waddr[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_num);
      rd_ptr <= rd_ptr + PW'(do_pop);
    end
  end

endmodule

// File: rtl/rob_marker_queue.sv
// Captures slti-x0 marker instructions from the ROB lanes into an event FIFO and
// tracks testcase phase, transient-window completion and simulation exit.
//
// phase    | meaning
// 0..6     | inside VCTM / DELAY / TEXE / LEAK / INIT / BIM / TRAIN section
// 7  EXIT  | SIM_EXIT committed; terminal until reset
// 15 IDLE  | between sections
module rob_marker_queue
  import rob_marker_pkg::*;
#(
  parameter int LANES = 2,
  parameter int IDW   = 6,
  parameter int DEPTH = 8,
  parameter int DELAY = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES*32-1:0]   in_inst,
  input  logic [LANES*IDW-1:0]  in_idx,
  input  logic                  in_deq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_code,
  output logic                  out_deq,
  output logic [IDW-1:0]        out_idx,
  output logic [3:0]            phase,
  output logic                  tsx_done,
  output logic                  sim_exit,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int CW = $clog2(LANES + 1);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int TW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  typedef struct packed {
    logic [3:0]     code;
    logic           deq;
    logic [IDW-1:0] idx;
  } lane_entry_t;

  logic [LANES-1:0]          is_mk;
  logic [3:0]                code [LANES];
  logic [CW-1:0]             prefix [LANES+1];
  lane_entry_t [LANES-1:0]   packed_e;
  lane_entry_t               head;
  logic [CW-1:0]             n_mk;
  logic [CW-1:0]             n_acc;
  logic [CW-1:0]             n_drop;
  logic [PW-1:0]             free;
  logic [8:0]                drop_sum;

  phase_t                    ph_q;
  phase_t                    ph_n;
  logic                      trig;
  logic                      exit_hit;
  logic                      armed;
  logic [TW-1:0]             tcnt;
  logic                      tsx_q;
  logic                      exit_q;
  logic                      ovf_q;
  logic [7:0]                drop_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      code[i]  = in_inst[32*i+20 +: 4];
      is_mk[i] = in_valid[i] & is_marker(in_inst[32*i +: 32]);
    end
  end

  // Slot j of the push vector takes the marker whose lane-order rank is j.
  always_comb begin
    prefix[0] = '0;
    for (int i = 0; i < LANES; i++) begin
      prefix[i+1] = prefix[i] + CW'(is_mk[i]);
    end
    for (int j = 0; j < LANES; j++) begin
      packed_e[j] = '0;
      for (int i = 0; i < LANES; i++) begin
        if (is_mk[i] && (prefix[i] == CW'(j))) begin
          packed_e[j] = '{code: code[i], deq: in_deq, idx: in_idx[IDW*i +: IDW]};
        end
      end
    end
  end

  assign n_mk     = prefix[LANES];
  assign n_acc    = (PW'(n_mk) > free) ? CW'(free) : n_mk;
  assign n_drop   = n_mk - n_acc;
  assign drop_sum = {1'b0, drop_q} + 9'(n_drop);

  marker_fifo #(
    .DEPTH   (DEPTH),
    .LANES   (LANES),
    .entry_t (lane_entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_data  (packed_e),
    .push_num   (n_acc),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head       (head),
    .free       (free)
  );

  // Commit-side markers walked in lane order so the last one in the cycle wins.
  always_comb begin
    ph_n     = ph_q;
    trig     = 1'b0;
    exit_hit = 1'b0;
    if (in_deq) begin
      for (int i = 0; i < LANES; i++) begin
        if (is_mk[i]) begin
          if (code[i] == VCTM_E || code[i] == TEXE_S) trig = 1'b1;
          if (code[i] == EXIT) exit_hit = 1'b1;
          if (ph_n != PH_EXIT) begin
            if (code[i] == EXIT)                          ph_n = PH_EXIT;
            else if (!code[i][0])                         ph_n = phase_t'({1'b0, code[i][3:1]});
            else if ({1'b0, code[i][3:1]} == 4'(ph_n))    ph_n = PH_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ph_q   <= PH_IDLE;
      armed  <= 1'b0;
      tcnt   <= '0;
      tsx_q  <= 1'b0;
      exit_q <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ph_q <= ph_n;
      if (exit_hit) exit_q <= 1'b1;
      if (n_drop != '0) begin
        ovf_q  <= 1'b1;
        drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
      // Terminal count at 1 so tsx_done lands exactly DELAY edges after the trigger.
      if (armed) begin
        if (tcnt == TW'(1)) begin
          armed <= 1'b0;
          tcnt  <= '0;
          tsx_q <= 1'b1;
        end else begin
          tcnt <= tcnt - TW'(1);
        end
      end else if (trig && !tsx_q) begin
        if (DELAY == 0) begin
          tsx_q <= 1'b1;
        end else begin
          armed <= 1'b1;
          tcnt  <= TW'(DELAY);
        end
      end
    end
  end

  assign out_code = head.code;
  assign out_deq  = head.deq;
  assign out_idx  = head.idx;
  assign phase    = ph_q;
  assign tsx_done = tsx_q;
  assign sim_exit = exit_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule
